// File: rtl/maze_ray_pkg.sv
// Shared widths, encodings and state type for the maze ray-parameter stage.
// Ports: none (package). Provides COORD_W/POS_W/P_W, P_INVALID, axis codes,
// and the get_param FSM state enum.
package maze_ray_pkg;

   localparam int COORD_W = 10;               // origin / direction width
   localparam int POS_W   = 18;               // position / target width
   localparam int P_W     = 10;               // step parameter width
   localparam int ITER_W  = 4;                // divider iteration index width
   localparam int CMP_W   = POS_W + 2;        // width of shifted-divisor compares

   localparam logic [P_W-1:0] P_INVALID = 10'h3FF;

   localparam logic [1:0] AXIS_X   = 2'd0;
   localparam logic [1:0] AXIS_Y   = 2'd1;
   localparam logic [1:0] AXIS_Z   = 2'd2;
   localparam logic [1:0] AXIS_ILL = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_DIV   = 2'd2,
      ST_HOLD  = 2'd3
   } get_param_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: compare remainder with dir<<i.
// Ports: rem_in/dir/i in; rem_out (remainder after optional subtract) and
// q_bit (quotient bit for position i) out. Purely combinational.
module div_step
   import maze_ray_pkg::*;
(
   input  logic [POS_W-1:0]   rem_in,
   input  logic [COORD_W-1:0] dir,
   input  logic [ITER_W-1:0]  i,
   output logic [POS_W-1:0]   rem_out,
   output logic               q_bit
);

   logic [CMP_W-1:0] shifted;
   logic [CMP_W-1:0] rem_ext;

   always_comb begin
      shifted = {{(CMP_W-COORD_W){1'b0}}, dir} << i;
      rem_ext = {2'b00, rem_in};
      q_bit   = (rem_ext >= shifted);
      rem_out = rem_in;
      // When the bit is set, shifted <= rem_in < 2^POS_W, so its low bits
      // carry the whole subtrahend.
      if (q_bit) begin
         rem_out = rem_in - shifted[POS_W-1:0];
      end
   end

endmodule

// File: rtl/get_param.sv
// Solves dir*p + ori = target on one axis: p = floor((target-ori)/dir).
// Ports: clk/rst; in_valid/in_ready request with axis, ori_*, dir_*, target;
// out_valid/out_ready result with out_p, out_rem, out_exact, out_err.
// Latency 1 edge for errors, 11 edges otherwise; result held until accepted.
module get_param
   import maze_ray_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         axis,
   input  logic [COORD_W-1:0] ori_x,
   input  logic [COORD_W-1:0] ori_y,
   input  logic [COORD_W-1:0] ori_z,
   input  logic [COORD_W-1:0] dir_x,
   input  logic [COORD_W-1:0] dir_y,
   input  logic [COORD_W-1:0] dir_z,
   input  logic [POS_W-1:0]   target,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [P_W-1:0]     out_p,
   output logic [P_W-1:0]     out_rem,
   output logic               out_exact,
   output logic               out_err
);

   get_param_state_t state, state_nxt;

   // Request captured in IDLE
   logic [1:0]         lat_axis;
   logic [COORD_W-1:0] lat_ori;
   logic [COORD_W-1:0] lat_dir;
   logic [POS_W-1:0]   lat_target;

   // Divider working registers
   logic [POS_W-1:0]   rem;
   logic [P_W-1:0]     quo;
   logic [ITER_W-1:0]  cnt;

   // Combinational helpers
   logic [POS_W:0]         diff;      // signed: MSB set means target < ori
   logic [COORD_W+P_W-1:0] limit;     // dir << 10, first quotient that overflows
   logic                   chk_err;
   logic [POS_W-1:0]       rem_nxt;
   logic                   q_bit;
   logic [P_W-1:0]         quo_nxt;
   logic [COORD_W-1:0]     sel_ori;
   logic [COORD_W-1:0]     sel_dir;

   always_comb begin
      sel_ori = '0;
      sel_dir = '0;
      case (axis)
         AXIS_X: begin sel_ori = ori_x; sel_dir = dir_x; end
         AXIS_Y: begin sel_ori = ori_y; sel_dir = dir_y; end
         AXIS_Z: begin sel_ori = ori_z; sel_dir = dir_z; end
         default: begin sel_ori = '0; sel_dir = '0; end
      endcase
   end

   always_comb begin
      diff    = {1'b0, lat_target} - {{(POS_W+1-COORD_W){1'b0}}, lat_ori};
      limit   = {lat_dir, {P_W{1'b0}}};
      // A non-negative diff at or above dir<<10 would need an 11th quotient bit.
      chk_err = (lat_axis == AXIS_ILL) || (lat_dir == '0) || diff[POS_W]
                || ({1'b0, diff} >= limit);
   end

   div_step u_div_step (
      .rem_in  (rem),
      .dir     (lat_dir),
      .i       (cnt),
      .rem_out (rem_nxt),
      .q_bit   (q_bit)
   );

   always_comb begin
      quo_nxt = quo | ({{(P_W-1){1'b0}}, q_bit} << cnt);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            state_nxt = chk_err ? ST_HOLD : ST_DIV;
         end
         ST_DIV: begin
            if (cnt == '0) state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_axis   <= '0;
         lat_ori    <= '0;
         lat_dir    <= '0;
         lat_target <= '0;
         rem        <= '0;
         quo        <= '0;
         cnt        <= '0;
         out_p      <= '0;
         out_rem    <= '0;
         out_exact  <= 1'b0;
         out_err    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  lat_axis   <= axis;
                  lat_ori    <= sel_ori;
                  lat_dir    <= sel_dir;
                  lat_target <= target;
               end
            end
            ST_CHECK: begin
               if (chk_err) begin
                  out_p     <= P_INVALID;
                  out_rem   <= '0;
                  out_exact <= 1'b0;
                  out_err   <= 1'b1;
               end else begin
                  rem <= diff[POS_W-1:0];
                  quo <= '0;
                  cnt <= ITER_W'(P_W - 1);
               end
            end
            ST_DIV: begin
               rem <= rem_nxt;
               quo <= quo_nxt;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  // Final remainder is below dir, so it fits the P_W-wide port.
                  out_p     <= quo_nxt;
                  out_rem   <= rem_nxt[P_W-1:0];
                  out_exact <= (rem_nxt == '0);
                  out_err   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
